// File: rtl/display_pkg.sv
// Shared XVGA 1024x768 timing constants and helpers for display/sprite blocks.
package display_pkg;

    localparam int unsigned XVGA_H_ACTIVE = 1024;
    localparam int unsigned XVGA_H_FP     = 24;
    localparam int unsigned XVGA_H_SYNC   = 136;
    localparam int unsigned XVGA_H_BP     = 160;
    localparam int unsigned XVGA_V_ACTIVE = 768;
    localparam int unsigned XVGA_V_FP     = 3;
    localparam int unsigned XVGA_V_SYNC   = 6;
    localparam int unsigned XVGA_V_BP     = 29;

    localparam int unsigned XVGA_H_TOTAL = XVGA_H_ACTIVE + XVGA_H_FP + XVGA_H_SYNC + XVGA_H_BP;
    localparam int unsigned XVGA_V_TOTAL = XVGA_V_ACTIVE + XVGA_V_FP + XVGA_V_SYNC + XVGA_V_BP;

    localparam int unsigned HCOUNT_W      = 11;
    localparam int unsigned VCOUNT_W      = 10;
    localparam int unsigned FRAME_COUNT_W = 8;

    // Idle levels: syncs are active-low, blank idles high in the delay line.
    localparam logic SYNC_IDLE  = 1'b1;
    localparam logic BLANK_IDLE = 1'b1;

    // True when pos lies in [lo, lo+len).
    function automatic logic in_window(input int unsigned pos,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register aligning a control bit with a downstream pixel pipeline.
module sync_delay_line
    import display_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = SYNC_IDLE
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    if (DEPTH == 0) begin : g_pass
        // Zero depth: straight pass-through of the already-registered input.
        logic w_unused;
        assign w_unused = i_clk ^ i_rst_n;
        assign o_q      = i_d;
    end else if (DEPTH == 1) begin : g_single
        logic r_stage;
        // Single stage register.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_stage <= RESET_VAL;
            else          r_stage <= i_d;
        end
        assign o_q = r_stage;
    end else begin : g_multi
        logic [DEPTH-1:0] r_stages;
        // Shift toward the MSB; the MSB is the oldest sample.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_stages <= {DEPTH{RESET_VAL}};
            else          r_stages <= {r_stages[DEPTH-2:0], i_d};
        end
        assign o_q = r_stages[DEPTH-1];
    end

endmodule

// File: rtl/xvga_timing_gen.sv
// XVGA raster timing: pixel/line counters with aligned sync, blank and frame markers.
module xvga_timing_gen
    import display_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = XVGA_H_ACTIVE,
    parameter int unsigned H_FP       = XVGA_H_FP,
    parameter int unsigned H_SYNC     = XVGA_H_SYNC,
    parameter int unsigned H_BP       = XVGA_H_BP,
    parameter int unsigned V_ACTIVE   = XVGA_V_ACTIVE,
    parameter int unsigned V_FP       = XVGA_V_FP,
    parameter int unsigned V_SYNC     = XVGA_V_SYNC,
    parameter int unsigned V_BP       = XVGA_V_BP,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out,
    output logic        frame_start_out,
    output logic [7:0]  frame_count_out,
    output logic        hsync_d_out,
    output logic        vsync_d_out,
    output logic        blank_d_out
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;

    logic [HCOUNT_W-1:0]      r_hcount;
    logic [VCOUNT_W-1:0]      r_vcount;
    logic                     r_hsync;
    logic                     r_vsync;
    logic                     r_blank;
    logic                     r_frame_start;
    logic [FRAME_COUNT_W-1:0] r_frame_count;

    logic                w_h_last;
    logic                w_v_last;
    logic                w_frame_wrap;
    logic [HCOUNT_W-1:0] w_hcount_nxt;
    logic [VCOUNT_W-1:0] w_vcount_nxt;
    logic                w_hsync_nxt;
    logic                w_vsync_nxt;
    logic                w_blank_nxt;

    // Next raster position and the sync/blank levels that belong to it.
    always_comb begin
        w_h_last     = (r_hcount == HCOUNT_W'(H_TOTAL - 1));
        w_v_last     = (r_vcount == VCOUNT_W'(V_TOTAL - 1));
        w_frame_wrap = w_h_last && w_v_last;
        w_hcount_nxt = w_h_last ? '0 : r_hcount + HCOUNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_last) begin
            w_vcount_nxt = w_v_last ? '0 : r_vcount + VCOUNT_W'(1);
        end
        w_hsync_nxt = !in_window(32'(w_hcount_nxt), HS_START, H_SYNC);
        w_vsync_nxt = !in_window(32'(w_vcount_nxt), VS_START, V_SYNC);
        w_blank_nxt = (32'(w_hcount_nxt) >= H_ACTIVE) || (32'(w_vcount_nxt) >= V_ACTIVE);
    end

    // Register counters together with their decoded levels so nothing skews.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_blank       <= w_blank_nxt;
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + FRAME_COUNT_W'(1);
            end
        end
    end

    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign hsync_out       = r_hsync;
    assign vsync_out       = r_vsync;
    assign blank_out       = r_blank;
    assign frame_start_out = r_frame_start;
    assign frame_count_out = r_frame_count;

    sync_delay_line #(.DEPTH(PIPE_DELAY), .RESET_VAL(SYNC_IDLE)) u_hsync_dly (
        .i_clk   (pixel_clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (r_hsync),
        .o_q     (hsync_d_out)
    );

    sync_delay_line #(.DEPTH(PIPE_DELAY), .RESET_VAL(SYNC_IDLE)) u_vsync_dly (
        .i_clk   (pixel_clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (r_vsync),
        .o_q     (vsync_d_out)
    );

    sync_delay_line #(.DEPTH(PIPE_DELAY), .RESET_VAL(BLANK_IDLE)) u_blank_dly (
        .i_clk   (pixel_clk_in),
        .i_rst_n (rst_n_in),
        .i_d     (r_blank),
        .o_q     (blank_d_out)
    );

endmodule

// File: doc/xvga_timing_gen.md
XVGA_TIMING_GEN -- requirements
Module: xvga_timing_gen

Interface
REQ-001 Parameters: name, default, meaning.
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch
- PIPE_DELAY, 2, cycles of sync/blank delay that align with downstream pixel pipeline; legal range 0..7

REQ-002 Ports: name, direction, width, meaning.
- pixel_clk_in, in, 1, pixel clock; only clock
- rst_n_in, in, 1, asynchronous active-low reset
- hcount_out, out, 11, current pixel column
- vcount_out, out, 10, current line
- hsync_out, out, 1, active-low hsync, aligned to counters
- vsync_out, out, 1, active-low vsync, aligned to counters
- blank_out, out, 1, high outside active region, aligned to counters
- frame_start_out, out, 1, one-cycle pulse when counters show (0,0) after wrap
- frame_count_out, out, 8, completed-frame counter
- hsync_d_out / vsync_d_out / blank_d_out, out, 1 each, copies of hsync/vsync/blank delayed PIPE_DELAY cycles

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806); both are compile-time constants.
REQ-004 hcount_out SHALL increment by 1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-005 vcount_out SHALL increment only on the cycle hcount wraps, and wrap from V_TOTAL-1 to 0 on that same cycle.
REQ-006 All outputs SHALL be registered; hsync/vsync/blank/frame_start SHALL correspond to the hcount/vcount values presented in the same cycle (no skew).
REQ-007 hsync_out SHALL be 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183).
REQ-008 vsync_out SHALL be 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776); vsync is evaluated per cycle, so its edges coincide with hcount=0.
REQ-009 blank_out SHALL be 1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
REQ-010 frame_start_out SHALL be 1 for exactly one cycle, only in the cycle the counters transition from (H_TOTAL-1,V_TOTAL-1) to (0,0); it SHALL NOT assert on the first (0,0) after reset.
REQ-011 frame_count_out SHALL increment in the same cycle frame_start_out asserts and wrap 255 -> 0.
REQ-012 Delayed outputs SHALL equal the undelayed outputs from exactly PIPE_DELAY cycles earlier; PIPE_DELAY=0 gives combinational pass-through of the registered values.

Reset
REQ-013 While rst_n_in=0 (asserted asynchronously, released synchronously to pixel_clk_in), the block SHALL hold hcount=0, vcount=0, hsync=1, vsync=1, blank=0, frame_start=0, and frame_count=0.
REQ-014 While rst_n_in=0, all delay-line stages SHALL hold the inactive values hsync_d=1, vsync_d=1, blank_d=1.
REQ-015 On the first clock edge after release, hcount SHALL become 1; reset mid-frame SHALL abandon the frame without a frame_start pulse.

Structure
REQ-016 The XVGA timing constants and the derived H_TOTAL/V_TOTAL SHALL live in shared package display_pkg, which sprite and display blocks import.
REQ-017 The delay line SHALL be a sub-module sync_delay_line, parameterized by depth and reset value and instantiated three times, once each for hsync, vsync and blank.

Verification
REQ-018 Reset release -> hcount goes 0,1,2 on successive edges; vcount=0; frame_start stays 0 through (1343,805).
REQ-019 hcount 1047 -> 1048 -> hsync_out goes 1 -> 0; it returns to 1 at hcount=1184; blank_out=1 from hcount=1024 to 1343.
REQ-020 Counters at (1343,770) -> next cycle (0,771) with vsync_out=0; vsync_out returns to 1 at (0,777).
REQ-021 Counters at (1343,805) -> next cycle (0,0) with frame_start_out=1 for one cycle and frame_count_out 0 -> 1; 256 frames -> frame_count_out back to 0.
REQ-022 PIPE_DELAY=2 -> hsync_d_out falls exactly 2 cycles after hsync_out; PIPE_DELAY=0 -> hsync_d_out is identical to hsync_out.
REQ-023 rst_n_in pulsed low at (500,300) -> outputs immediately (asynchronously) show reset values, with no frame_start pulse before the next full frame completes.
